// File: rtl/apb_ram_completer_pkg.sv
// ---------------------------------------------------------------------------
// apb_ram_completer_pkg
// Shared types and constants for the APB4 RAM completer:
//   - APB bus width defaults used by the interface and the completer
//   - completer FSM state enum (prefixed so it can coexist with the
//     requester's own IDLE/READY literals)
//   - bit positions of the individual error causes in the error vector
// ---------------------------------------------------------------------------
package apb_ram_completer_pkg;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_STRB_WIDTH = APB_DATA_WIDTH / 8;

  // Wait counter is sized for 0..15 wait states.
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    CMP_IDLE  = 2'd0,
    CMP_WAIT  = 2'd1,
    CMP_READY = 2'd2
  } apb_cmp_state_e;

  // Bit positions inside the error-cause vector.
  localparam int ERR_RANGE  = 0;  // word index beyond the RAM
  localparam int ERR_ALIGN  = 1;  // byte address not word aligned
  localparam int ERR_RDSTRB = 2;  // read issued with non-zero strobes
  localparam int ERR_PROT   = 3;  // unprivileged access when privilege is required
  localparam int ERR_NUM    = 4;

endpackage

// File: rtl/apb_ram_completer_if.sv
// ---------------------------------------------------------------------------
// apb_ram_completer_if
// APB4 bus bundle between a requester and the RAM completer.
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB/PPROT : requester -> completer
//   PREADY/PRDATA/PSLVERR                        : completer -> requester
// Modports: master (requester side), slave (completer side).
// ---------------------------------------------------------------------------
interface apb_ram_completer_if
  import apb_ram_completer_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH
);

  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [2:0]              PPROT;
  logic                    PREADY;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PREADY, PRDATA, PSLVERR
  );

endinterface

// File: rtl/apb_ram_completer_ram_bank.sv
// ---------------------------------------------------------------------------
// apb_ram_bank
// Single-port DEPTH x DATA_W RAM with per-byte write enables and a
// registered (synchronous) read port. Contents and read register are not
// reset.
//   clk_i    : clock
//   addr_i   : word address, shared by read and write
//   rd_en_i  : load rdata_o from mem[addr_i] at the next edge
//   wr_en_i  : write enable, qualified per byte by be_i
//   be_i     : byte enables
//   wdata_i  : write data
//   rdata_o  : registered read data (holds when rd_en_i is low)
// ---------------------------------------------------------------------------
module apb_ram_bank #(
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic [IDX_W-1:0]      addr_i,
  input  logic                  rd_en_i,
  input  logic                  wr_en_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < DATA_W / 8; k++) begin
      if (wr_en_i && be_i[k]) begin
        mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_ram_completer.sv
// ---------------------------------------------------------------------------
// apb_ram_completer
// APB4 completer in front of a word-organised, byte-writable RAM.
// A setup cycle latches the request and its error flag; the FSM then
// spends WAIT_CYCLES cycles in WAIT before a one-cycle READY completion.
// Reads are returned in the READY cycle; writes commit at the closing edge
// of READY. Errored transfers never touch the RAM and return PRDATA=0 on
// reads.
//   PCLK     : APB clock
//   PRESETn  : asynchronous active-low reset
//   apb      : APB4 slave modport (PSEL..PPROT in, PREADY/PRDATA/PSLVERR out)
// ---------------------------------------------------------------------------
module apb_ram_completer
  import apb_ram_completer_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 1,
  parameter int PRIV_ONLY   = 0
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  apb_ram_completer_if.slave apb
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_WIDTH / 8;

  // FSM and latched request
  apb_cmp_state_e          state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    wr_q;
  logic [IDX_W-1:0]        idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       strb_q;
  logic                    err_q;

  // Registered bus outputs
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic                    rd_from_ram_q, rd_from_ram_d;

  // Decode of the live bus
  logic                    setup;
  logic                    req_ld;
  logic [ADDR_WIDTH-1:0]   word_idx_full;
  logic [ERR_NUM-1:0]      err_cause;
  logic                    live_err;

  // Request as seen by the current cycle: live bus on the setup cycle,
  // latched copy afterwards. Needed so WAIT_CYCLES=0 can complete straight
  // out of IDLE.
  logic                    cur_wr;
  logic                    cur_err;
  logic [IDX_W-1:0]        cur_idx;
  logic                    enter_ready;

  // RAM port
  logic                    ram_rd_en;
  logic                    ram_wr_en;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  // Only PPROT[0] carries meaning here.
  logic                    unused_prot;
  assign unused_prot = ^apb.PPROT[2:1];

  assign setup         = apb.PSEL & ~apb.PENABLE;
  assign req_ld        = (state_q == CMP_IDLE) & setup;
  assign word_idx_full = {2'b00, apb.PADDR[ADDR_WIDTH-1:2]};

  always_comb begin
    err_cause             = '0;
    err_cause[ERR_RANGE]  = word_idx_full >= ADDR_WIDTH'(MEM_DEPTH);
    err_cause[ERR_ALIGN]  = |apb.PADDR[1:0];
    err_cause[ERR_RDSTRB] = ~apb.PWRITE & (|apb.PSTRB);
    err_cause[ERR_PROT]   = (PRIV_ONLY != 0) & ~apb.PPROT[0];
  end

  assign live_err = |err_cause;

  assign cur_wr  = req_ld ? apb.PWRITE                 : wr_q;
  assign cur_err = req_ld ? live_err                   : err_q;
  assign cur_idx = req_ld ? apb.PADDR[IDX_W+1:2]       : idx_q;

  // ---- FSM: state register ----
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= CMP_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CMP_IDLE: begin
        if (setup) begin
          if (WAIT_CYCLES == 0) begin
            state_d = CMP_READY;
          end else begin
            state_d = CMP_WAIT;
            cnt_d   = WAIT_CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      CMP_WAIT: begin
        // Requester dropping PSEL mid-wait abandons the transfer.
        if (!apb.PSEL) begin
          state_d = CMP_IDLE;
        end else if (cnt_q == '0) begin
          state_d = CMP_READY;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      CMP_READY: begin
        state_d = CMP_IDLE;
      end
      default: begin
        state_d = CMP_IDLE;
      end
    endcase
  end

  // ---- FSM: outputs and RAM control ----
  always_comb begin
    enter_ready   = (state_d == CMP_READY);
    pready_d      = enter_ready;
    pslverr_d     = enter_ready & cur_err;
    ram_rd_en     = enter_ready & ~cur_wr & ~cur_err;
    // Write commits at the closing edge of the completion cycle.
    ram_wr_en     = (state_q == CMP_READY) & wr_q & ~err_q;
    rd_from_ram_d = rd_from_ram_q;
    // PRDATA is either the RAM read register or zero; writes leave the
    // selection (and therefore PRDATA) untouched.
    if (enter_ready && !cur_wr) begin
      rd_from_ram_d = ~cur_err;
    end
  end

  // ---- Request latch and registered outputs ----
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_q          <= 1'b0;
      idx_q         <= '0;
      wdata_q       <= '0;
      strb_q        <= '0;
      err_q         <= 1'b0;
      pready_q      <= 1'b0;
      pslverr_q     <= 1'b0;
      rd_from_ram_q <= 1'b0;
    end else begin
      if (req_ld) begin
        wr_q    <= apb.PWRITE;
        idx_q   <= apb.PADDR[IDX_W+1:2];
        wdata_q <= apb.PWDATA;
        strb_q  <= apb.PSTRB;
        err_q   <= live_err;
      end
      pready_q      <= pready_d;
      pslverr_q     <= pslverr_d;
      rd_from_ram_q <= rd_from_ram_d;
    end
  end

  apb_ram_bank #(
    .DEPTH  (MEM_DEPTH),
    .IDX_W  (IDX_W),
    .DATA_W (DATA_WIDTH)
  ) u_bank (
    .clk_i   (PCLK),
    .addr_i  (cur_idx),
    .rd_en_i (ram_rd_en),
    .wr_en_i (ram_wr_en),
    .be_i    (strb_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign apb.PRDATA  = rd_from_ram_q ? ram_rdata : '0;

endmodule

// File: tb/tb_apb_ram_completer.sv
// ---------------------------------------------------------------------------
// tb_apb_ram_completer
// Two completers share one set of bus drivers: u_dut0 (no wait states,
// any privilege) and u_dut1 (three wait states, privileged only). dsel
// steers PSEL and the returned signals. A word-array model per instance
// predicts read data, error responses and latency.
// ---------------------------------------------------------------------------
module tb_apb_ram_completer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  bit          dsel = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  pprot = 3'b001;

  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  int checks = 0;
  int passed = 0;

  logic [31:0] mem_m [2][256];
  int          wc [2] = '{0, 3};
  bit          priv [2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  apb_ram_completer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
  apb_ram_completer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();

  assign b0.PSEL    = psel & ~dsel;
  assign b1.PSEL    = psel & dsel;
  assign b0.PENABLE = penable;
  assign b1.PENABLE = penable;
  assign b0.PWRITE  = pwrite;
  assign b1.PWRITE  = pwrite;
  assign b0.PADDR   = paddr;
  assign b1.PADDR   = paddr;
  assign b0.PWDATA  = pwdata;
  assign b1.PWDATA  = pwdata;
  assign b0.PSTRB   = pstrb;
  assign b1.PSTRB   = pstrb;
  assign b0.PPROT   = pprot;
  assign b1.PPROT   = pprot;

  assign pready  = dsel ? b1.PREADY  : b0.PREADY;
  assign pslverr = dsel ? b1.PSLVERR : b0.PSLVERR;
  assign prdata  = dsel ? b1.PRDATA  : b0.PRDATA;

  apb_ram_completer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256),
    .WAIT_CYCLES(0), .PRIV_ONLY(0)
  ) u_dut0 (
    .PCLK(clk), .PRESETn(rst_n), .apb(b0.slave)
  );

  apb_ram_completer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256),
    .WAIT_CYCLES(3), .PRIV_ONLY(1)
  ) u_dut1 (
    .PCLK(clk), .PRESETn(rst_n), .apb(b1.slave)
  );

  // ---------------- reference model ----------------
  function automatic bit exp_err(bit d, bit wr, logic [31:0] a, logic [3:0] st, logic [2:0] pr);
    return (a / 4 >= 256) || (a % 4 != 0) || (!wr && st != 4'h0) || (priv[d] && !pr[0]);
  endfunction

  task automatic m_write(bit d, logic [31:0] a, logic [31:0] wd, logic [3:0] st, logic [2:0] pr);
    if (!exp_err(d, 1'b1, a, st, pr)) begin
      for (int k = 0; k < 4; k++)
        if (st[k]) mem_m[d][a / 4][8*k +: 8] = wd[8*k +: 8];
    end
  endtask

  function automatic logic [31:0] m_read(bit d, logic [31:0] a, logic [3:0] st, logic [2:0] pr);
    if (exp_err(d, 1'b0, a, st, pr)) return 32'h0;
    return mem_m[d][a / 4];
  endfunction

  // ---------------- bus driver ----------------
  // Setup at one negedge, access from the next; returns the number of
  // access cycles seen with PREADY low, or -1 if PREADY never came.
  // Leaves PSEL/PENABLE high so a following call is back-to-back.
  task automatic xfer(input bit d, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                      output logic [31:0] rd, output logic err, output int waits);
    @(negedge clk);
    dsel = d; psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = a; pwdata = wd; pstrb = st; pprot = pr;
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    while (pready !== 1'b1 && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    if (pready !== 1'b1) waits = -1;
    rd  = prdata;
    err = pslverr;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (b0.PREADY !== 1'b0) $display("FAIL reset_pready0: got %b want 0", b0.PREADY); else passed++;
    checks++; if (b0.PSLVERR !== 1'b0) $display("FAIL reset_pslverr0: got %b want 0", b0.PSLVERR); else passed++;
    checks++; if (b0.PRDATA !== 32'h0) $display("FAIL reset_prdata0: got %h want 0", b0.PRDATA); else passed++;
    checks++; if (b1.PREADY !== 1'b0) $display("FAIL reset_pready1: got %b want 0", b1.PREADY); else passed++;
    checks++; if (b1.PSLVERR !== 1'b0) $display("FAIL reset_pslverr1: got %b want 0", b1.PSLVERR); else passed++;
    checks++; if (b1.PRDATA !== 32'h0) $display("FAIL reset_prdata1: got %h want 0", b1.PRDATA); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    logic [31:0] rd, wd; logic err; int w; int bad = 0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) begin
        wd = $urandom;
        xfer(d[0], 1'b1, i * 4, wd, 4'hF, 3'b001, rd, err, w);
        m_write(d[0], i * 4, wd, 4'hF, 3'b001);
        if (err !== 1'b0 || w != wc[d]) bad++;
      end
    end
    bus_idle();
    checks++; if (bad != 0) $display("FAIL init_writes: %0d bad completions, want 0", bad); else passed++;
  endtask

  task automatic test_full_write_read();
    logic [31:0] rd; logic err; int w;
    xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, rd, err, w);
    m_write(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000);
    checks++; if (w != 0) $display("FAIL w0_write_latency: got %0d want 0", w); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL w0_write_err: got %b want 0", err); else passed++;
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (w != 0) $display("FAIL w0_read_latency: got %0d want 0", w); else passed++;
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL w0_read_data: got %h want deadbeef", rd); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL w0_read_err: got %b want 0", err); else passed++;
    bus_idle();
  endtask

  task automatic test_partial_strobe();
    logic [31:0] rd; logic err; int w;
    xfer(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 3'b000, rd, err, w);
    m_write(1'b0, 32'h20, 32'h11223344, 4'hF, 3'b000);
    xfer(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 3'b000, rd, err, w);
    m_write(1'b0, 32'h20, 32'hAABBCCDD, 4'b0101, 3'b000);
    xfer(1'b0, 1'b1, 32'h24, 32'h55555555, 4'h0, 3'b000, rd, err, w);
    checks++; if (err !== 1'b0) $display("FAIL strb0_write_err: got %b want 0", err); else passed++;
    xfer(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (rd !== 32'h11BB33DD) $display("FAIL partial_strobe: got %h want 11bb33dd", rd); else passed++;
    xfer(1'b0, 1'b0, 32'h24, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (rd !== mem_m[0][9]) $display("FAIL strb0_noop: got %h want %h", rd, mem_m[0][9]); else passed++;
    bus_idle();
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int w;
    xfer(1'b1, 1'b1, 32'h08, 32'h0BADF00D, 4'hF, 3'b001, rd, err, w);
    m_write(1'b1, 32'h08, 32'h0BADF00D, 4'hF, 3'b001);
    checks++; if (w != 3) $display("FAIL w3_write_latency: got %0d want 3", w); else passed++;
    xfer(1'b1, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, err, w);
    checks++; if (w != 3) $display("FAIL w3_read_latency: got %0d want 3", w); else passed++;
    checks++; if (rd !== 32'h0BADF00D) $display("FAIL w3_read_data: got %h want 0badf00d", rd); else passed++;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    checks++; if (pready !== 1'b0) $display("FAIL w3_pready_width: got %b want 0", pready); else passed++;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int w;
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'h1, 3'b000, rd, err, w);
    checks++; if (err !== 1'b1) $display("FAIL rdstrb_err: got %b want 1", err); else passed++;
    checks++; if (rd !== 32'h0) $display("FAIL rdstrb_data: got %h want 0", rd); else passed++;
    xfer(1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 3'b000, rd, err, w);
    checks++; if (err !== 1'b1) $display("FAIL range_err: got %b want 1", err); else passed++;
    xfer(1'b0, 1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, 3'b000, rd, err, w);
    checks++; if (err !== 1'b1) $display("FAIL align_err: got %b want 1", err); else passed++;
    xfer(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (rd !== mem_m[0][0]) $display("FAIL word0_unchanged: got %h want %h", rd, mem_m[0][0]); else passed++;
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (rd !== mem_m[0][4]) $display("FAIL word4_unchanged: got %h want %h", rd, mem_m[0][4]); else passed++;
    xfer(1'b1, 1'b1, 32'h30, ~mem_m[1][12], 4'hF, 3'b000, rd, err, w);
    checks++; if (err !== 1'b1 || w != 3) $display("FAIL prot_err: got err=%b waits=%0d want err=1 waits=3", err, w); else passed++;
    xfer(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 3'b001, rd, err, w);
    checks++; if (rd !== mem_m[1][12] || err !== 1'b0) $display("FAIL prot_unchanged: got %h err=%b want %h err=0", rd, err, mem_m[1][12]); else passed++;
    bus_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int w;
    xfer(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 3'b001, rd, err, w);
    m_write(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 3'b001);
    xfer(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 3'b001, rd, err, w);
    checks++; if (rd !== 32'hCAFEF00D) $display("FAIL pre_reset_read: got %h want cafef00d", rd); else passed++;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h40;
    pwdata = 32'h12345678; pstrb = 4'hF; pprot = 3'b001;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (pready !== 1'b0) $display("FAIL midrst_pready: got %b want 0", pready); else passed++;
    checks++; if (pslverr !== 1'b0) $display("FAIL midrst_pslverr: got %b want 0", pslverr); else passed++;
    checks++; if (prdata !== 32'h0) $display("FAIL midrst_prdata: got %h want 0", prdata); else passed++;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 3'b001, rd, err, w);
    checks++; if (rd !== 32'hCAFEF00D || w != 3) $display("FAIL midrst_nowrite: got %h waits=%0d want cafef00d waits=3", rd, w); else passed++;
    bus_idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int w; int highs = 0;
    @(negedge clk);
    dsel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h50;
    pwdata = ~mem_m[1][20]; pstrb = 4'hF; pprot = 3'b001;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pready !== 1'b0) highs++;
    end
    checks++; if (highs != 0) $display("FAIL abort_pready: %0d cycles high, want 0", highs); else passed++;
    xfer(1'b1, 1'b0, 32'h50, 32'h0, 4'h0, 3'b001, rd, err, w);
    checks++; if (rd !== mem_m[1][20] || w != 3) $display("FAIL abort_nowrite: got %h waits=%0d want %h waits=3", rd, w, mem_m[1][20]); else passed++;
    bus_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, a, wd, exp; logic err; int w; bit d, wr, eerr;
    logic [3:0] st; logic [2:0] pr; int r;
    for (int i = 0; i < 80; i++) begin
      d  = $urandom_range(0, 1);
      wr = $urandom_range(0, 1);
      a  = $urandom_range(0, 31) * 4;
      r  = $urandom_range(0, 9);
      if (r == 0) a = a + $urandom_range(1, 3);
      if (r == 1) a = a + 32'h400;
      st = wr ? 4'($urandom) : ((r == 2) ? 4'($urandom_range(1, 15)) : 4'h0);
      pr = (r == 3) ? 3'b000 : 3'($urandom) | 3'b001;
      wd = $urandom;
      eerr = exp_err(d, wr, a, st, pr);
      exp  = m_read(d, a, st, pr);
      xfer(d, wr, a, wd, st, pr, rd, err, w);
      checks++; if (w != wc[d]) $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, w, wc[d]); else passed++;
      checks++; if (err !== eerr) $display("FAIL b2b_err[%0d]: got %b want %b", i, err, eerr); else passed++;
      if (wr) m_write(d, a, wd, st, pr);
      else begin
        checks++; if (rd !== exp) $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rd, exp); else passed++;
      end
    end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_init();
    test_full_write_read();
    test_partial_strobe();
    test_wait_states();
    test_errors();
    test_reset_mid();
    test_abort();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/apb_ram_completer.md
Name: apb_ram_completer

Overview:
- APB4 completer (slave) fronting a word-organised byte-writable RAM; the responder side of the APB4 bus driven by the team's requester/golden-model FSM.
- Decodes setup/access phases, inserts a configurable number of wait states, applies standard byte-lane write strobes, and flags errors via PSLVERR.
- Sits directly on the APB bus behind the interconnect and is the DUT for the APB4 RAM UVM environment.

Parameters:
- ADDR_WIDTH, 32, PADDR width in bits.
- DATA_WIDTH, 32, PWDATA/PRDATA width; fixed at 32 for this revision.
- MEM_DEPTH, 256, number of 32-bit words.
- WAIT_CYCLES, 1, wait states inserted per transfer (0..15).
- PRIV_ONLY, 0, when 1, transfers with PPROT[0]=0 are errored.

Ports:
- PCLK  in  1  APB clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- PSEL  in  1  completer select.
- PENABLE  in  1  access phase indicator.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte strobes.
- PPROT  in  3  protection attributes.
- PREADY  out  1  transfer completion, registered.
- PRDATA  out  DATA_WIDTH  read data, registered.
- PSLVERR  out  1  error response, valid only while PREADY=1.

Behaviour:
- Reset (async, PRESETn=0): state=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, wait counter=0, latched request cleared. RAM contents are not reset. Reset mid-transfer abandons the transfer and performs no write.
- Word index = PADDR[ADDR_WIDTH-1:2].
- Error conditions, evaluated at setup:
  - word index >= MEM_DEPTH
  - PADDR[1:0] != 0
  - read with PSTRB != 0
  - PRIV_ONLY=1 and PPROT[0]=0
- FSM states: IDLE, WAIT, READY.
- IDLE, on a setup cycle (PSEL=1, PENABLE=0):
  - Latch PWRITE, word index, PWDATA, PSTRB and the error flag.
  - If WAIT_CYCLES=0, go to READY; otherwise go to WAIT with cnt=WAIT_CYCLES-1.
- WAIT:
  - If PSEL=0 (aborted transfer), go to IDLE with no side effects.
  - Else if cnt=0, go to READY; else decrement cnt.
- Entering READY (registered on the same edge):
  - PREADY<=1 and PSLVERR<=err.
  - Read with no error: PRDATA<=RAM[idx].
  - Read with error: PRDATA<=0.
  - Write: PRDATA holds its previous value.
- READY is the completion cycle:
  - At its closing edge a non-error write commits RAM[idx][8k+7:8k]<=PWDATA_latched[8k+7:8k] for each k with PSTRB[k]=1; unstrobed bytes are unchanged.
  - PSTRB=0 write is a legal no-op.
  - An errored write never modifies the RAM.
  - Next state is always IDLE; PREADY<=0, PSLVERR<=0; PRDATA holds.
- Latency: setup at cycle T0 gives PREADY high in cycle T1+WAIT_CYCLES, exactly one cycle wide.
- Back-to-back transfers: a new setup in the cycle after completion is accepted from IDLE.
- No sign extension or data manipulation on writes or reads.
- PSEL/PENABLE sampled during READY are ignored (completion edge).
- Read-after-write to the same word returns the merged data.

Decomposition:
- shared_pkg:
  - apb_cmp_state_e {IDLE, WAIT, READY}; the IDLE/READY names collide with the requester's state_e literals, so the enum is prefixed (CMP_IDLE, CMP_WAIT, CMP_READY).
  - Error-cause localparams: ERR_RANGE, ERR_ALIGN, ERR_RDSTRB, ERR_PROT.
- apb_defines.svh: reuse APB_ADDR_WIDTH, APB_DATA_WIDTH, APB_STRB_WIDTH.
- Sub-module apb_ram_bank: single-port MEM_DEPTH x 32 RAM with per-byte write enables and synchronous read, no reset.

Test Plan:
- WAIT_CYCLES=0: write 0xDEADBEEF to 0x10 with PSTRB=4'hF, then read 0x10 -> PREADY in the first access cycle both times, PRDATA=0xDEADBEEF, PSLVERR=0.
- Partial strobes: word 0x20 holds 0x11223344; write 0xAABBCCDD with PSTRB=4'b0101 -> read returns 0x11BB33DD.
- WAIT_CYCLES=3 -> PREADY low for exactly 3 access cycles, high on the 4th, one cycle wide.
- Errors, each with PSLVERR=1 and the target word unchanged on a later read:
  - read with PSTRB=4'h1: PRDATA=0.
  - write to 0x0000_0400 with MEM_DEPTH=256.
  - write to 0x0000_0002 (misaligned).
  - PRIV_ONLY=1 with PPROT=3'b000.
- Reset mid-transfer: write with PRESETn asserted low during a WAIT cycle -> PREADY=0, PSLVERR=0 and PRDATA=0 immediately; no write commits; the next transfer works normally.
- Abort and back-to-back:
  - PSEL dropped in WAIT -> FSM returns to IDLE and no write occurs.
  - Setup issued in the cycle after completion -> accepted with correct latency.
